// File: rtl/float_sub_seq.sv
// Multi-cycle binary16 subtractor (res = float_a - float_b) with valid/ready on both sides.
// Alignment and normalisation walk one bit per cycle; subnormals flush to zero, rounding truncates.
module float_sub_seq #(
  parameter int float_width    = 16,
  parameter int mantissa_width = 10,
  parameter int exponent_width = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [float_width-1:0] float_a,
  input  logic [float_width-1:0] float_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [float_width-1:0] res
);

  localparam int FW = float_width;
  localparam int MW = mantissa_width;
  localparam int EW = exponent_width;
  localparam int SW = MW + 4;   // hidden + fraction + 3 guard bits
  localparam int CW = SW + 1;   // plus carry
  localparam logic [EW-1:0] EXP_MAX   = '1;
  localparam logic [EW-1:0] CLEAR_CNT = EW'(SW);
  localparam logic [FW-1:0] QNAN      = {1'b0, EXP_MAX, 1'b1, {(MW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   big_reg, big_next;       // larger-exponent significand, later the magnitude
  logic [SW-1:0]   small_reg, small_next;
  logic            sign_big_reg, sign_big_next;
  logic            sign_small_reg, sign_small_next;
  logic [EW-1:0]   exp_reg, exp_next;
  logic [EW-1:0]   cnt_reg, cnt_next;
  logic [FW-1:0]   res_reg, res_next;

  logic [EW-1:0]   exp_a, exp_b;
  logic [MW-1:0]   frac_a, frac_b;
  logic [SW-1:0]   sig_a, sig_b;
  logic [FW-1:0]   special_res;
  logic            nan_a, nan_b, inf_a, inf_b;

  assign exp_a  = float_a[FW-2 -: EW];
  assign exp_b  = float_b[FW-2 -: EW];
  assign frac_a = float_a[MW-1:0];
  assign frac_b = float_b[MW-1:0];
  assign sig_a  = (exp_a != '0) ? {1'b1, frac_a, 3'b000} : '0;
  assign sig_b  = (exp_b != '0) ? {1'b1, frac_b, 3'b000} : '0;
  assign nan_a  = (exp_a == EXP_MAX) && (frac_a != '0);
  assign nan_b  = (exp_b == EXP_MAX) && (frac_b != '0);
  assign inf_a  = (exp_a == EXP_MAX) && (frac_a == '0);
  assign inf_b  = (exp_b == EXP_MAX) && (frac_b == '0);

  always_comb begin
    special_res = {~float_b[FW-1], float_b[FW-2:0]};
    if (nan_a || nan_b)
      special_res = QNAN;
    else if (inf_a && inf_b)
      special_res = (float_a[FW-1] == float_b[FW-1]) ? QNAN : float_a;
    else if (inf_a)
      special_res = float_a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      big_reg        <= '0;
      small_reg      <= '0;
      sign_big_reg   <= 1'b0;
      sign_small_reg <= 1'b0;
      exp_reg        <= '0;
      cnt_reg        <= '0;
      res_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      big_reg        <= big_next;
      small_reg      <= small_next;
      sign_big_reg   <= sign_big_next;
      sign_small_reg <= sign_small_next;
      exp_reg        <= exp_next;
      cnt_reg        <= cnt_next;
      res_reg        <= res_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    big_next        = big_reg;
    small_next      = small_reg;
    sign_big_next   = sign_big_reg;
    sign_small_next = sign_small_reg;
    exp_next        = exp_reg;
    cnt_next        = cnt_reg;
    res_next        = res_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          if (exp_a == EXP_MAX || exp_b == EXP_MAX) begin
            res_next   = special_res;
            state_next = DONE;
          end else begin
            // subtrahend sign is flipped here so the rest of the path is a plain add
            if (exp_a >= exp_b) begin
              big_next        = {1'b0, sig_a};
              sign_big_next   = float_a[FW-1];
              small_next      = sig_b;
              sign_small_next = ~float_b[FW-1];
              exp_next        = exp_a;
              cnt_next        = exp_a - exp_b;
            end else begin
              big_next        = {1'b0, sig_b};
              sign_big_next   = ~float_b[FW-1];
              small_next      = sig_a;
              sign_small_next = float_a[FW-1];
              exp_next        = exp_b;
              cnt_next        = exp_b - exp_a;
            end
            state_next = ALIGN;
          end
        end
      end
      ALIGN: begin
        if (cnt_reg == '0) begin
          state_next = ADD;
        end else if (cnt_reg >= CLEAR_CNT) begin
          small_next = '0;
          cnt_next   = '0;
        end else begin
          small_next = small_reg >> 1;
          cnt_next   = cnt_reg - EW'(1);
        end
      end
      ADD: begin
        if (sign_big_reg == sign_small_reg) begin
          big_next = big_reg + {1'b0, small_reg};
        end else if (big_reg >= {1'b0, small_reg}) begin
          big_next = big_reg - {1'b0, small_reg};
        end else begin
          big_next      = {1'b0, small_reg} - big_reg;
          sign_big_next = sign_small_reg;
        end
        state_next = NORM;
      end
      NORM: begin
        if (big_reg == '0) begin
          res_next   = '0;
          state_next = DONE;
        end else if (exp_reg == EXP_MAX) begin
          res_next   = {sign_big_reg, EXP_MAX, {MW{1'b0}}};
          state_next = DONE;
        end else if (big_reg[CW-1]) begin
          big_next = big_reg >> 1;
          exp_next = exp_reg + EW'(1);
        end else if (exp_reg == '0) begin
          res_next   = {sign_big_reg, {(FW-1){1'b0}}};
          state_next = DONE;
        end else if (!big_reg[SW-1]) begin
          big_next = big_reg << 1;
          exp_next = exp_reg - EW'(1);
        end else begin
          res_next   = {sign_big_reg, exp_reg, big_reg[SW-2 -: MW]};
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign res       = res_reg;

endmodule

// File: tb/tb_float_sub_seq.sv
// Randomised self-checking bench for float_sub_seq against an arithmetic reference model.
// Latency is counted in rising edges after the accept edge until out_valid is seen high.
module tb_float_sub_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] float_a = '0;
  logic [15:0] float_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] res;

  int n_vec = 0;
  int n_err = 0;

  float_sub_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .float_a   (float_a),
    .float_b   (float_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_vec++;
    if (got !== expv) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // Reference: exact integer arithmetic on scaled significands, then a direct msb search.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output int lat);
    int ea, eb, ma, mb, sa, sb, d, e, sum, mag, p, ne, nshift, ashift, norm;
    logic sgn;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    if (ea == 31 || eb == 31) begin
      lat = 0;
      if ((ea == 31 && a[9:0] != 0) || (eb == 31 && b[9:0] != 0)) r = 16'h7E00;
      else if (ea == 31 && eb == 31) r = (a[15] == b[15]) ? 16'h7E00 : a;
      else if (ea == 31) r = a;
      else r = {~b[15], b[14:0]};
      return;
    end
    ma = (ea != 0) ? (1024 + int'(a[9:0])) * 8 : 0;
    mb = (eb != 0) ? (1024 + int'(b[9:0])) * 8 : 0;
    d  = (ea >= eb) ? ea - eb : eb - ea;
    e  = (ea >= eb) ? ea : eb;
    ashift = (d >= 14) ? 1 : d;
    if (ea >= eb) mb = (d >= 14) ? 0 : (mb >> d);
    else          ma = (d >= 14) ? 0 : (ma >> d);
    sa  = a[15] ? -ma : ma;
    sb  = b[15] ? mb : -mb;
    sum = sa + sb;
    if (sum == 0) begin
      r = 16'h0000;
      lat = 3 + ashift;
      return;
    end
    sgn = (sum < 0);
    mag = sgn ? -sum : sum;
    p = 0;
    for (int i = 0; i < 16; i++) if ((mag >> i) & 1) p = i;
    ne = e + p - 13;
    if (ne >= 31) begin
      r = {sgn, 5'h1F, 10'h000};
      nshift = p - 13;
    end else if (ne <= 0) begin
      r = {sgn, 15'h0000};
      nshift = e;
    end else begin
      norm = (p > 13) ? (mag >> (p - 13)) : (mag << (13 - p));
      r = {sgn, ne[4:0], 10'((norm >> 3) & 1023)};
      nshift = (p > 13) ? p - 13 : 13 - p;
    end
    lat = 3 + ashift + nshift;
  endfunction

  // One transaction; 'hold' cycles of backpressure with junk in_valid traffic before out_ready.
  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input int hold);
    logic [15:0] er;
    int el, lat;
    logic seen;
    model(a, b, er, el);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    float_a = a;
    float_b = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    float_a = 16'($urandom);
    float_b = 16'($urandom);
    lat = 0;
    seen = out_valid;
    while (!seen && lat < 100) begin
      out_ready = 1'($urandom);
      @(posedge clk);
      #1;
      lat++;
      seen = out_valid;
    end
    out_ready = 1'b0;
    check("out_valid_seen", seen, 1);
    check("latency", lat, el);
    check("res", res, er);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      float_a = 16'($urandom);
      float_b = 16'($urandom);
      @(posedge clk);
      #1;
      check("hold_valid", out_valid, 1);
      check("hold_res", res, er);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("ready_after_hs", in_ready, 1);
    check("valid_after_hs", out_valid, 0);
    $display("txn a=%04h b=%04h res=%04h exp=%04h lat=%0d exp_lat=%0d", a, b, res, er, lat, el);
  endtask

  function automatic logic [15:0] rand_operand(input int base_exp);
    int sel, ex;
    logic [15:0] v;
    sel = int'($urandom_range(0, 15));
    v = 16'($urandom);
    if (sel == 0) ex = 31;
    else if (sel == 1) ex = 0;
    else if (base_exp < 0) ex = int'($urandom_range(1, 30));
    else begin
      ex = base_exp + int'($urandom_range(0, 32)) - 16;
      if (ex < 1) ex = 1;
      if (ex > 30) ex = 30;
    end
    v[14:10] = 5'(ex);
    return v;
  endfunction

  initial begin
    logic [15:0] ra, rb;
    #3;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_res", res, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    run_txn(16'h3C00, 16'h3800, 0);
    run_txn(16'h3C00, 16'h3C00, 0);
    run_txn(16'h4000, 16'hC000, 0);
    run_txn(16'h7BFF, 16'hFBFF, 0);
    run_txn(16'h7C00, 16'h7C00, 0);
    run_txn(16'h7C00, 16'hFC00, 0);
    run_txn(16'h3C00, 16'h7C00, 0);
    run_txn(16'h7C01, 16'h3C00, 0);
    run_txn(16'h4000, 16'h0001, 0);
    run_txn(16'h4000, 16'h0401, 0);
    run_txn(16'h0400, 16'h03FF, 0);
    run_txn(16'h0800, 16'h07FF, 0);
    run_txn(16'h8000, 16'h8000, 0);
    run_txn(16'h3C00, 16'h3800, 10);

    // abort during ALIGN: async reset must drop straight back to idle
    @(negedge clk);
    float_a = 16'h4000;
    float_b = 16'h3400;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      check("abort_quiet", out_valid, 0);
    end
    run_txn(16'h4000, 16'h3400, 0);

    for (int i = 0; i < 300; i++) begin
      ra = rand_operand(-1);
      rb = rand_operand(int'(ra[14:10]));
      run_txn(ra, rb, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
